// File: rtl/demux_pkg.sv
// Shared definitions for the serial-to-parallel demultiplexer.
package demux_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SEL_W_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/decoder_n.sv
// SEL_W-to-WIDTH one-hot decoder with enable; all outputs low when en=0.
module decoder_n #(
    parameter int SEL_W = 4,
    parameter int WIDTH = 16
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    output logic [WIDTH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_s2p.sv
// 1-to-WIDTH serial demultiplexer: bits are collected LSB-first and handed
// out as a registered word over a valid/ready handshake.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | waiting for start; serial input ignored, in_ready low
//  FILL  | collecting bits into position idx; words issued back-to-back
module demux_s2p
    import demux_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W-1:0] bit_idx,
    output logic             frame_err
);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    // The last bit of a word goes straight to out, so the collector holds
    // only the lower WIDTH-1 positions.
    logic [WIDTH-2:0] coll_q, coll_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_err_q, frame_err_d;

    logic             acc;
    logic             cons;
    logic [SEL_W-1:0] wr_idx;
    logic [WIDTH-1:0] we;

    assign in_ready = (state_q == FILL) &&
                      !((idx_q == SEL_W'(WIDTH - 1)) && out_valid_q && !out_ready);
    assign acc      = in_valid && in_ready;
    assign cons     = out_valid_q && out_ready;
    // A start in FILL restarts the word, so a same-cycle bit lands in slot 0.
    assign wr_idx   = start ? '0 : idx_q;

    decoder_n #(
        .SEL_W (SEL_W),
        .WIDTH (WIDTH)
    ) u_dec (
        .sel    (wr_idx),
        .en     (acc),
        .onehot (we)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        coll_d      = coll_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    idx_d   = '0;
                    coll_d  = '0;
                end
            end
            FILL: begin
                if (start) begin
                    idx_d       = '0;
                    coll_d      = '0;
                    frame_err_d = (idx_q != '0);
                end
                if (acc) begin
                    idx_d = wr_idx + SEL_W'(1);
                end
                for (int i = 0; i < WIDTH - 1; i++) begin
                    if (we[i]) begin
                        coll_d[i] = in_bit;
                    end
                end
                if (we[WIDTH-1]) begin
                    out_d = {in_bit, coll_q};
                end
            end
        endcase

        if (we[WIDTH-1]) begin
            out_valid_d = 1'b1;
        end else if (cons) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            coll_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            coll_q      <= coll_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign bit_idx   = idx_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_demux_s2p.sv
// Directed bench for demux_s2p: a vector table for IDLE/start/frame-error
// behaviour plus hand-written sequences for word assembly and back-pressure.
module tb_demux_s2p;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_bit;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  bit_idx;
    logic        frame_err;

    int n_tests = 0;
    int n_fail  = 0;

    demux_s2p #(.WIDTH(16), .SEL_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bit_idx   (bit_idx),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic        in_valid;
        logic        in_bit;
        logic        out_ready;
        logic        exp_in_ready;
        logic        exp_out_valid;
        logic [3:0]  exp_idx;
        logic        exp_frame_err;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Feed bits [from, from+n) of w, one per cycle, checking in_ready each time.
    task automatic send_bits(input logic [15:0] w, input int from, input int n);
        for (int i = from; i < from + n; i++) begin
            in_valid = 1'b1;
            in_bit   = w[i];
            #1;
            chk($sformatf("in_ready bit%0d", i), 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    initial begin
        // rst start iv ib ordy | ir ov idx fe out
        vecs[0]  = '{0, 0, 1, 1, 0,  0, 0, 4'd0, 0, 16'h0000};
        vecs[1]  = '{0, 0, 1, 0, 1,  0, 0, 4'd0, 0, 16'h0000};
        vecs[2]  = '{0, 0, 0, 1, 1,  0, 0, 4'd0, 0, 16'h0000};
        vecs[3]  = '{0, 0, 1, 1, 1,  0, 0, 4'd0, 0, 16'h0000};
        vecs[4]  = '{0, 1, 1, 1, 1,  1, 0, 4'd0, 0, 16'h0000};
        vecs[5]  = '{0, 0, 1, 1, 1,  1, 0, 4'd1, 0, 16'h0000};
        vecs[6]  = '{0, 0, 1, 0, 1,  1, 0, 4'd2, 0, 16'h0000};
        vecs[7]  = '{0, 0, 0, 1, 1,  1, 0, 4'd2, 0, 16'h0000};
        vecs[8]  = '{0, 1, 1, 1, 1,  1, 0, 4'd1, 1, 16'h0000};
        vecs[9]  = '{0, 0, 0, 0, 1,  1, 0, 4'd1, 0, 16'h0000};
        vecs[10] = '{1, 0, 1, 1, 1,  0, 0, 4'd0, 0, 16'h0000};
        vecs[11] = '{0, 0, 1, 1, 1,  0, 0, 4'd0, 0, 16'h0000};

        rst = 1'b1; start = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("reset out", 32'(out), 32'h0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset bit_idx", 32'(bit_idx), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset frame_err", 32'(frame_err), 32'd0);

        // IDLE ignore, start, mid-word restart, reset
        for (int v = 0; v < 12; v++) begin
            rst = vecs[v].rst; start = vecs[v].start; in_valid = vecs[v].in_valid;
            in_bit = vecs[v].in_bit; out_ready = vecs[v].out_ready;
            tick();
            chk($sformatf("vec%0d in_ready", v), 32'(in_ready), 32'(vecs[v].exp_in_ready));
            chk($sformatf("vec%0d out_valid", v), 32'(out_valid), 32'(vecs[v].exp_out_valid));
            chk($sformatf("vec%0d bit_idx", v), 32'(bit_idx), 32'(vecs[v].exp_idx));
            chk($sformatf("vec%0d frame_err", v), 32'(frame_err), 32'(vecs[v].exp_frame_err));
            chk($sformatf("vec%0d out", v), 32'(out), 32'(vecs[v].exp_out));
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;

        // Single word 0xA5C3
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bits(16'hA5C3, 0, 15);
        chk("t1 no early valid", 32'(out_valid), 32'd0);
        send_bits(16'hA5C3, 15, 1);
        chk("t1 out", 32'(out), 32'hA5C3);
        chk("t1 out_valid", 32'(out_valid), 32'd1);
        chk("t1 bit_idx wrap", 32'(bit_idx), 32'd0);

        // Back-to-back words with out_ready held high
        send_bits(16'h0001, 0, 16);
        chk("t2 w1 out", 32'(out), 32'h0001);
        chk("t2 w1 valid", 32'(out_valid), 32'd1);
        send_bits(16'h8000, 0, 1);
        chk("t2 consumed", 32'(out_valid), 32'd0);
        chk("t2 out kept", 32'(out), 32'h0001);
        send_bits(16'h8000, 1, 15);
        chk("t2 w2 out", 32'(out), 32'h8000);
        chk("t2 w2 valid", 32'(out_valid), 32'd1);

        // Back-pressure: word 2 stalls at its last bit until out_ready
        in_valid = 1'b0;
        tick();
        chk("t3 drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        send_bits(16'h1234, 0, 16);
        chk("t3 w1 out", 32'(out), 32'h1234);
        chk("t3 w1 valid", 32'(out_valid), 32'd1);
        send_bits(16'hDAF0, 0, 15);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        #1;
        chk("t3 stall in_ready", 32'(in_ready), 32'd0);
        chk("t3 stall bit_idx", 32'(bit_idx), 32'd15);
        tick();
        tick();
        chk("t3 hold out", 32'(out), 32'h1234);
        chk("t3 hold valid", 32'(out_valid), 32'd1);
        chk("t3 hold bit_idx", 32'(bit_idx), 32'd15);
        chk("t3 hold in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("t3 release in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("t3 w2 out", 32'(out), 32'hDAF0);
        chk("t3 w2 valid", 32'(out_valid), 32'd1);
        chk("t3 w2 bit_idx", 32'(bit_idx), 32'd0);
        tick();
        chk("t3 w2 consumed", 32'(out_valid), 32'd0);
        chk("t3 out kept", 32'(out), 32'hDAF0);

        // Start at idx 7 discards the partial word
        send_bits(16'hFFFF, 0, 7);
        chk("t4 idx7", 32'(bit_idx), 32'd7);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4 frame_err", 32'(frame_err), 32'd1);
        chk("t4 bit_idx", 32'(bit_idx), 32'd0);
        chk("t4 no out", 32'(out_valid), 32'd0);
        tick();
        chk("t4 frame_err pulse", 32'(frame_err), 32'd0);
        send_bits(16'h3C96, 0, 16);
        chk("t4 clean out", 32'(out), 32'h3C96);
        chk("t4 clean valid", 32'(out_valid), 32'd1);
        chk("t4 no err", 32'(frame_err), 32'd0);

        // Reset mid-word with a pending output
        out_ready = 1'b0;
        send_bits(16'h01FF, 0, 9);
        chk("t5 idx9", 32'(bit_idx), 32'd9);
        chk("t5 pending", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5 out", 32'(out), 32'h0);
        chk("t5 out_valid", 32'(out_valid), 32'd0);
        chk("t5 bit_idx", 32'(bit_idx), 32'd0);
        chk("t5 in_ready", 32'(in_ready), 32'd0);

        // IDLE after reset ignores serial traffic
        for (int i = 0; i < 6; i++) begin
            in_valid = i[0];
            in_bit   = i[1];
            tick();
            chk($sformatf("t6 in_ready %0d", i), 32'(in_ready), 32'd0);
            chk($sformatf("t6 bit_idx %0d", i), 32'(bit_idx), 32'd0);
            chk($sformatf("t6 out_valid %0d", i), 32'(out_valid), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
